// File: rtl/mux_rr_scanner.sv
// rtl/mux_rr_scanner.sv - round-robin 8:1 mux select controller with registered valid/ready output
// Optional: define MUX_RR_FIXED_PRIORITY_EN to pin the search pointer at 0 (fixed priority).
module mux_rr_scanner #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   req,
    input  logic [N-1:0] mux_dout,
    output logic [2:0]   sel,
    output logic [7:0]   grant,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   sel_q, sel_d;
    logic [7:0]   grant_q, grant_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic [7:0]   ack_q, ack_d;

    logic [2:0]   pick;
    logic [2:0]   cand;
    logic         found;

    // Circular search starting at ptr; the 3-bit add wraps 7 -> 0 naturally.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    grant_d = 8'd1 << pick;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                out_data_d  = mux_dout;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                // sel is left as-is after the transfer so the mux input stays quiet.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    grant_d     = '0;
                    ack_d       = grant_q;
                    ptr_d       = sel_q + 3'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MUX_RR_FIXED_PRIORITY_EN
        ptr_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ack       = ack_q;

endmodule

// File: tb/tb_mux_rr_scanner.sv
// tb/tb_mux_rr_scanner.sv - self-checking bench for mux_rr_scanner
module tb_mux_rr_scanner;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   req;
    logic [N-1:0] mux_dout;
    logic [2:0]   sel;
    logic [7:0]   grant;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   ack;

    logic [N-1:0] data_a [8];

    typedef struct {
        logic [7:0] req;
        int         stall;
        logic [2:0] sel_rr;
        logic [2:0] sel_fp;
    } vec_t;

    typedef struct {
        logic [2:0]   sel;
        logic [N-1:0] data;
    } exp_t;

    vec_t vecs [9];
    exp_t sb_q [$];
    logic [7:0] exp_ack = '0;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_scanner #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .mux_dout(mux_dout),
        .sel(sel), .grant(grant), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .ack(ack)
    );

    always #5 clk = ~clk;

    assign mux_dout = data_a[sel];

    function automatic logic [7:0] oh(input logic [2:0] s);
        return 8'd1 << s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: inputs settle at negedge, sampled 1 time unit later.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            exp_ack = '0;
        end else begin
            check("ack", {24'd0, ack}, {24'd0, exp_ack});
            exp_ack = '0;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_transfer", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("xfer_sel", {29'd0, sel}, {29'd0, e.sel});
                    check("xfer_grant", {24'd0, grant}, {24'd0, oh(e.sel)});
                    check("xfer_data", {24'd0, out_data}, {24'd0, e.data});
                    exp_ack = oh(e.sel);
                end
            end
        end
    end

    task automatic run_txn(input logic [7:0] r, input int stall, input logic [2:0] es);
        int t;
        sb_q.push_back('{sel: es, data: data_a[es]});
        req       = r;
        out_ready = (stall == 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (grant == 8'd0 && t < 10);
        check("txn_grant", {24'd0, grant}, {24'd0, oh(es)});
        req = '0;
        if (stall > 0) begin
            t = 0;
            while (!out_valid && t < 10) begin
                @(negedge clk);
                t++;
            end
            for (int s = 0; s < stall; s++) begin
                check("stall_hold", {out_valid, out_data, sel, grant},
                      {1'b1, data_a[es], es, oh(es)});
                @(negedge clk);
            end
            out_ready = 1'b1;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (out_valid && t < 20);
        check("txn_done", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int t;
        logic [2:0] es;
        for (int i = 0; i < 8; i++) data_a[i] = 8'h13 * 8'(i + 1);
        data_a[4] = 8'hA5;

        vecs[0] = '{req: 8'h03, stall: 0, sel_rr: 3'd0, sel_fp: 3'd0};
        vecs[1] = '{req: 8'h01, stall: 5, sel_rr: 3'd0, sel_fp: 3'd0};
        vecs[2] = '{req: 8'h20, stall: 0, sel_rr: 3'd5, sel_fp: 3'd5};
        vecs[3] = '{req: 8'h83, stall: 0, sel_rr: 3'd7, sel_fp: 3'd0};
        vecs[4] = '{req: 8'h83, stall: 0, sel_rr: 3'd0, sel_fp: 3'd0};
        vecs[5] = '{req: 8'h83, stall: 0, sel_rr: 3'd1, sel_fp: 3'd0};
        vecs[6] = '{req: 8'h81, stall: 2, sel_rr: 3'd7, sel_fp: 3'd0};
        vecs[7] = '{req: 8'h40, stall: 1, sel_rr: 3'd6, sel_fp: 3'd6};
        vecs[8] = '{req: 8'h41, stall: 0, sel_rr: 3'd0, sel_fp: 3'd0};

        rst = 1'b1; req = '0; out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", {12'd0, sel, grant, out_valid, ack}, 32'd0);
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_outputs", {12'd0, sel, grant, out_valid, ack}, 32'd0);
        end

        // Single request: latency of grant, data capture and ack.
        sb_q.push_back('{sel: 3'd4, data: 8'hA5});
        req = 8'h10; out_ready = 1'b1;
        @(negedge clk);
        check("lat_sel_grant", {23'd0, sel, grant, out_valid}, {23'd0, 3'd4, 8'h10, 1'b0});
        req = '0;
        @(negedge clk);
        check("lat_valid_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA5});
        @(negedge clk);
        check("lat_after_xfer", {31'd0, out_valid}, 32'd0);
        @(negedge clk);

        // Table: ptr is 5 here (wrap to 0), then back-pressure, skip and wrap cases.
        for (int v = 0; v < 9; v++) begin
`ifdef MUX_RR_FIXED_PRIORITY_EN
            es = vecs[v].sel_fp;
`else
            es = vecs[v].sel_rr;
`endif
            run_txn(vecs[v].req, vecs[v].stall, es);
        end

        // Asynchronous reset while holding a word.
        req = 8'h08; out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("hold_reached", {31'd0, out_valid}, 32'd1);
        req = '0;
        #2 rst = 1'b1;
        #1 check("async_reset", {12'd0, sel, grant, out_valid, ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fairness from ptr=0 with all requests held.
        for (int i = 0; i < 16; i++) begin
`ifdef MUX_RR_FIXED_PRIORITY_EN
            es = 3'd0;
`else
            es = 3'(i % 8);
`endif
            sb_q.push_back('{sel: es, data: data_a[es]});
        end
        req = 8'hFF; out_ready = 1'b1;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        req = '0;
        check("fairness_done", 32'(sb_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("final_idle", {23'd0, grant, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_scanner.md
Name: mux_rr_scanner

Overview:
- Upstream controller for the N-bit 8:1 select mux.
- Arbitrates 8 request lines round-robin and drives the mux's 3-bit select.
- Registers the mux output one cycle after select is stable, then presents it downstream with a valid/ready handshake.
- Sits between eight requesting sources (each feeding one mux data input a0..a7) and a single downstream consumer.

Parameters:
- N, 8, data width of each mux input and of the captured output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i] high means source i (mux input ai) has data.
- mux_dout  input  N  combinational output of the 8:1 mux driven by sel.
- sel  output  3  select to the 8:1 mux; registered.
- grant  output  8  one-hot grant to the selected source; registered; 0 when idle.
- out_data  output  N  captured word for downstream.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream can accept.
- ack  output  8  one-cycle one-hot pulse to the source whose word was consumed.

Behaviour:
- Reset (async, rst=1):
  - sel=0, grant=0, out_data=0, out_valid=0, ack=0.
  - Priority pointer ptr=0; state=IDLE.
  - Asserting rst mid-transfer aborts it immediately; no ack is issued.
- State machine: IDLE -> SELECT -> HOLD -> IDLE.
- IDLE:
  - ack=0.
  - If req==0, stay in IDLE.
  - Otherwise pick idx = first set bit of req searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - Next edge: sel<=idx, grant<=onehot(idx), state<=SELECT.
- SELECT (exactly 1 cycle):
  - sel is stable, so the mux output has settled.
  - Next edge: out_data<=mux_dout, out_valid<=1, state<=HOLD.
- HOLD:
  - out_data, sel and grant are held constant while out_valid=1 and out_ready=0.
  - On an edge with out_valid=1 and out_ready=1 (transfer):
    - out_valid<=0, grant<=0, ack<=onehot(idx) for exactly 1 cycle.
    - ptr<=(idx+1) mod 8, state<=IDLE.
  - sel keeps its last value after the transfer; it is not cleared.
- Latency and throughput:
  - req seen at edge k -> sel/grant valid after edge k -> out_valid after edge k+1.
  - With out_ready held high, the transfer occurs at edge k+2.
  - Minimum 3 cycles per word.
  - The IDLE cycle that carries the ack pulse may simultaneously select the next request.
- Request handling:
  - req changes during SELECT/HOLD are ignored; the arbitration result is committed.
  - Deassertion of the granted req[idx] before the transfer does not cancel it.
  - out_ready asserted while out_valid=0 has no effect.
- Wrap-around: idx=7 sets ptr to 0; searching from ptr=5 with req=8'b0000_0011 selects idx=0.
- Fairness: with all req bits held high, grants cycle 0, 1, 2, ..., 7, 0, ...
- Width: out_data is exactly N bits, no extension. sel is always in 0..7.

Optional Feature:
- Macro: MUX_RR_FIXED_PRIORITY_EN.
- Defined: ptr is held at 0 permanently, so the lowest-index set req always wins (fixed priority). ack and handshake are unchanged.
- Undefined (default): round-robin pointer behaviour as above.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles, then rst=0 with req=0 for 10 cycles.
  - Required: sel=0, grant=0, out_valid=0, ack=0 throughout.
- Single request with latency:
  - Stimulus: req=8'b0001_0000, a4 data=8'hA5 (via mux model), out_ready=1.
  - Required: sel=4 and grant=8'h10 one cycle after req; out_valid=1 with out_data=8'hA5 the next cycle; ack=8'h10 pulse after transfer.
- Back-pressure:
  - Stimulus: req=8'h01, out_ready=0 for 5 cycles, then 1.
  - Required: out_valid, out_data, sel and grant all constant through the stall; exactly one ack pulse; no duplicate transfer.
- Round-robin fairness:
  - Stimulus: req=8'hFF held, out_ready=1.
  - Required: 16 transfers with sel sequence 0..7, 0..7.
  - With MUX_RR_FIXED_PRIORITY_EN defined: all 16 transfers have sel=0.
- Wrap and skip:
  - Stimulus: complete a transfer with sel=5, then req=8'b1000_0011.
  - Required: next sel=7, then sel=0, then sel=1.
- Mid-transfer reset:
  - Stimulus: assert rst asynchronously while in HOLD with out_valid=1.
  - Required: out_valid, grant and ack go 0 immediately (before the next edge); after release, arbitration restarts from ptr=0.
